demod_carrier_ctrl: RTL
=======================

DEMOD_CARRIER_CTRL -- requirements
Module: demod_carrier_ctrl

Interface
REQ-001 Parameter WIN_LOG2, default 4: window length is 2^WIN_LOG2 valid error samples.
REQ-002 Parameter THRESH, default 64: in-band limit on the window sum magnitude.
REQ-003 Parameter LOCK_WINS, default 4: consecutive in-band windows required to declare lock.
REQ-004 Ports shall be listed clock and reset first: clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  level; 1 runs the loop, 0 parks the controller.
REQ-007 err_valid  in  1  qualifies err for one cycle.
REQ-008 err  in  8  signed phase-error sample from the I/Q mixer products.
REQ-009 v  out  1  registered phase-offset select driving the demodulator VCO advance input.
REQ-010 locked  out  1  registered, 1 only in state TRACK.
REQ-011 win_done  out  1  registered single-cycle pulse marking each window evaluation.

Function
REQ-012 States shall be IDLE, ACQ and TRACK.
REQ-013 IDLE shall move to ACQ on the first cycle en=1; ACQ or TRACK shall move to IDLE on the first cycle en=0.
REQ-014 In ACQ or TRACK, each err_valid=1 cycle shall add sign-extended err to an accumulator of 8+WIN_LOG2 bits (no overflow possible) and increment the sample counter.
REQ-015 The cycle accepting sample 2^WIN_LOG2 shall evaluate the sum including that sample, clear accumulator and counter, and assert win_done on the next cycle only.
REQ-016 At evaluation: sum > THRESH sets v=1; sum < -THRESH sets v=0; otherwise v holds (boundary |sum| == THRESH is in-band).
REQ-017 In-band window: increment the good-window counter; out-of-band window: clear it.
REQ-018 ACQ shall move to TRACK at the evaluation where the good-window counter reaches LOCK_WINS.
REQ-019 TRACK shall move to ACQ on any out-of-band window and clear the good-window counter.
REQ-020 v, and the updated state/locked, shall change in the cycle after the evaluating sample, coincident with win_done.
REQ-021 Leaving for IDLE shall discard the partial window (accumulator, sample and good counters cleared) while v holds its value; locked=0.
REQ-022 In IDLE, err_valid and err shall be ignored.

Reset
REQ-023 rst_n low shall immediately force IDLE, v=0, locked=0, win_done=0, all counters and accumulator 0.
REQ-024 Reset asserted mid-window shall discard that window; after release the first window needs a full 2^WIN_LOG2 samples.

Configuration
REQ-025 With DEMOD_CTRL_STATS_EN defined: extra port slip_cnt  out  8, counting every change of v, saturating at 255, cleared only by reset.
REQ-026 Without DEMOD_CTRL_STATS_EN: port slip_cnt and its counter shall be absent; all other behaviour identical.

Structure
REQ-027 The state enumeration and the err width constant (8) shall live in shared package demod_pkg.
REQ-028 The accumulate-and-dump window shall be a sub-module demod_err_acc (sum, count, done); the state machine stays in the top.

Verification (WIN_LOG2=4, THRESH=64, LOCK_WINS=4)
REQ-029 en=1, 16 samples err=+10 -> sum 160, win_done one cycle after sample 16, v=1, locked=0.
REQ-030 4 windows of err=0 -> locked=1 coincident with the 4th win_done; then 16 samples err=-10 -> v=0, locked=0, state ACQ.
REQ-031 16 samples summing exactly +64 and then exactly -64 -> v unchanged, both counted as in-band.
REQ-032 16 samples err=-128 -> sum -2048 without wrap, v=0; err_valid gaps between samples shall not shorten the window.
REQ-033 en dropped after 7 samples, restored -> no win_done until 16 further samples; rst_n pulsed mid-window -> all outputs 0 immediately.
REQ-034 STATS build: alternate +10/-10 windows 300 times -> slip_cnt saturates at 255.

Source files
------------

// File: rtl/demod_pkg.sv
// demod_pkg: definitions shared by the carrier-recovery controller and its
// error accumulator.
//   ERR_W   : width of the signed phase-error sample from the mixer products
//   state_e : controller states (IDLE parked, ACQ acquiring, TRACK locked)
package demod_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_e;

endpackage

// File: rtl/demod_err_acc.sv
// demod_err_acc: accumulate-and-dump window over 2^WIN_LOG2 accepted
// phase-error samples.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   clr        : discard the partial window (accumulator and count to 0)
//   take       : accept err this cycle
//   err        : signed phase-error sample
//   sum        : accumulated sum including the sample being accepted now
//   done       : high in the cycle that accepts the last sample of a window;
//                sum is the complete window sum in that cycle
module demod_err_acc
  import demod_pkg::*;
#(
  parameter int WIN_LOG2 = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clr,
  input  logic                              take,
  input  logic [ERR_W-1:0]                  err,
  output logic signed [ERR_W+WIN_LOG2-1:0]  sum,
  output logic                              done
);

  localparam int AW = ERR_W + WIN_LOG2;

  logic signed [AW-1:0]   acc_q, acc_d;
  logic [WIN_LOG2-1:0]    cnt_q, cnt_d;

  always_comb begin
    // AW bits hold 2^WIN_LOG2 full-scale samples, so the sum can never wrap.
    sum   = acc_q + {{WIN_LOG2{err[ERR_W-1]}}, err};
    done  = take && (cnt_q == {WIN_LOG2{1'b1}});
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      if (done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + WIN_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demod_carrier_ctrl.sv
// demod_carrier_ctrl: carrier-recovery lock controller. Windows of phase-error
// samples are summed; a strongly positive/negative window steers the VCO
// phase-offset select v, and LOCK_WINS consecutive in-band windows declare lock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   en         : 1 runs the loop, 0 parks the controller in IDLE
//   err_valid  : qualifies err for one cycle
//   err        : signed phase-error sample
//   v          : registered phase-offset select to the VCO advance input
//   locked     : registered, 1 only in TRACK
//   win_done   : registered one-cycle pulse per window evaluation
//   slip_cnt   : (only with DEMOD_CTRL_STATS_EN) saturating count of v changes
// Optional build macro: DEMOD_CTRL_STATS_EN adds slip_cnt and its counter.
module demod_carrier_ctrl
  import demod_pkg::*;
#(
  parameter int WIN_LOG2  = 4,
  parameter int THRESH    = 64,
  parameter int LOCK_WINS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             err_valid,
  input  logic [ERR_W-1:0] err,
  output logic             v,
  output logic             locked,
  output logic             win_done
`ifdef DEMOD_CTRL_STATS_EN
  ,
  output logic [7:0]       slip_cnt
`endif
);

  localparam int AW = ERR_W + WIN_LOG2;
  localparam int GW = $clog2(LOCK_WINS + 1);
  localparam logic signed [AW-1:0] THR_POS = AW'(THRESH);
  localparam logic signed [AW-1:0] THR_NEG = -THR_POS;

  state_e              state_q, state_d;
  logic                v_q, v_d;
  logic                locked_q, locked_d;
  logic                win_done_q, win_done_d;
  logic [GW-1:0]       good_q, good_d;
  logic [GW-1:0]       good_inc;

  logic                active;
  logic                take;
  logic                acc_done;
  logic signed [AW-1:0] acc_sum;
  logic                above, below, in_band;

  // Samples are only accepted while running; any other cycle (IDLE, or the
  // cycle en drops) clears the partial window.
  assign active = (state_q != IDLE) && en;
  assign take   = active && err_valid;

  demod_err_acc #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!active),
    .take  (take),
    .err   (err),
    .sum   (acc_sum),
    .done  (acc_done)
  );

  // |sum| == THRESH counts as in-band.
  assign above   = acc_sum > THR_POS;
  assign below   = acc_sum < THR_NEG;
  assign in_band = !above && !below;

  // Good-window count saturates at LOCK_WINS; staying in TRACK needs no more.
  assign good_inc = (good_q >= GW'(LOCK_WINS)) ? good_q : good_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    good_d     = good_q;
    win_done_d = acc_done;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = ACQ;
      end
      ACQ, TRACK: begin
        if (!en) begin
          state_d = IDLE;
          good_d  = '0;
        end else if (acc_done) begin
          if (above) v_d = 1'b1;
          if (below) v_d = 1'b0;
          if (in_band) begin
            good_d = good_inc;
            if (good_inc >= GW'(LOCK_WINS)) state_d = TRACK;
          end else begin
            good_d  = '0;
            state_d = ACQ;
          end
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      v_q        <= 1'b0;
      locked_q   <= 1'b0;
      win_done_q <= 1'b0;
      good_q     <= '0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      locked_q   <= locked_d;
      win_done_q <= win_done_d;
      good_q     <= good_d;
    end
  end

  assign v        = v_q;
  assign locked   = locked_q;
  assign win_done = win_done_q;

`ifdef DEMOD_CTRL_STATS_EN
  logic [7:0] slip_q, slip_d;

  always_comb begin
    slip_d = slip_q;
    if ((v_d != v_q) && (slip_q != 8'hFF)) slip_d = slip_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slip_q <= 8'd0;
    else        slip_q <= slip_d;
  end

  assign slip_cnt = slip_q;
`endif

endmodule
